// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, counter op encoding and width helper for the register file scoreboard
package regfile_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_ADDR_W       = 4;
  localparam int DEF_PC_REG       = 15;
  localparam int DEF_MAX_INFLIGHT = 3;

  // Net effect of one cycle on a pending-write counter
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Bits needed to hold 0..max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// rtl/regfile_scoreboard_pending_counter.sv - saturating up/down pending-write counter with underflow pulse
module pending_counter
  import regfile_pkg::*;
#(
  parameter int MAX_VAL = DEF_MAX_INFLIGHT,
  parameter int CNT_W   = cnt_width(MAX_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  cnt_op_e op;

  // Simultaneous inc and dec cancel; only a lone request moves the count
  always_comb begin
    op = CNT_HOLD;
    if (inc && !dec) begin
      op = CNT_INC;
    end else if (dec && !inc) begin
      op = CNT_DEC;
    end
  end

  // A write-back with nothing outstanding is a scoreboard protocol error
  always_comb begin
    underflow = dec && (count == '0);
  end

  // Counter state; clamps at both ends instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case (op)
        CNT_INC: if (count != MAX_CNT) count <= count + 1'b1;
        CNT_DEC: if (count != '0)      count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-back bypass and per-register pending-write scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int PC_REG       = DEF_PC_REG,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           rd_sel_0,
  input  logic [ADDR_W-1:0]           rd_sel_1,
  output logic [WIDTH-1:0]            rd_data_0,
  output logic [WIDTH-1:0]            rd_data_1,
  output logic                        rd_busy_0,
  output logic                        rd_busy_1,
  input  logic [WIDTH-1:0]            pc_in,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_dst,
  output logic                        issue_stall,
  input  logic                        wb_valid,
  input  logic [ADDR_W-1:0]           wb_dst,
  input  logic [WIDTH-1:0]            wb_data,
  output logic                        sb_error,
  output logic [(2**ADDR_W)*WIDTH-1:0] regs_flat
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam int                CNT_W    = cnt_width(MAX_INFLIGHT);
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_REG);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_INFLIGHT);

  logic [WIDTH-1:0]    mem  [NUM_REGS];
  logic [CNT_W-1:0]    pend [NUM_REGS];
  logic [NUM_REGS-1:0] uflow_vec;

  logic wb_hit_0;
  logic wb_hit_1;
  logic wb_hit_issue;

  assign wb_hit_0     = wb_valid && (wb_dst == rd_sel_0);
  assign wb_hit_1     = wb_valid && (wb_dst == rd_sel_1);
  assign wb_hit_issue = wb_valid && (wb_dst == issue_dst);

  // Refuse an issue only when its destination is full and no slot frees up this cycle
  always_comb begin
    issue_stall = issue_valid && (issue_dst != PC_ADDR) &&
                  (pend[issue_dst] == MAX_CNT) && !wb_hit_issue;
  end

  // One counter per architectural register; the PC alias is never tracked
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    if (r == PC_REG) begin : g_pc
      assign pend[r]      = '0;
      assign uflow_vec[r] = 1'b0;
    end else begin : g_cnt
      logic inc_r;
      logic dec_r;
      assign inc_r = issue_valid && !issue_stall && (issue_dst == ADDR_W'(r));
      assign dec_r = wb_valid && (wb_dst == ADDR_W'(r));
      pending_counter #(
        .MAX_VAL (MAX_INFLIGHT),
        .CNT_W   (CNT_W)
      ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_r),
        .dec       (dec_r),
        .count     (pend[r]),
        .underflow (uflow_vec[r])
      );
    end
  end

  // Rising-edge storage; writes aimed at the PC alias are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_valid && (wb_dst != PC_ADDR)) begin
      mem[wb_dst] <= wb_data;
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if (|uflow_vec) begin
      sb_error <= 1'b1;
    end
  end

  // Read port 0: PC alias, then write-back bypass, then storage
  always_comb begin
    if (rd_sel_0 == PC_ADDR) begin
      rd_data_0 = pc_in;
    end else if (wb_hit_0) begin
      rd_data_0 = wb_data;
    end else begin
      rd_data_0 = mem[rd_sel_0];
    end
  end

  // Read port 1: same priority as port 0
  always_comb begin
    if (rd_sel_1 == PC_ADDR) begin
      rd_data_1 = pc_in;
    end else if (wb_hit_1) begin
      rd_data_1 = wb_data;
    end else begin
      rd_data_1 = mem[rd_sel_1];
    end
  end

  // Busy means writes remain outstanding after counting the one landing now
  always_comb begin
    rd_busy_0 = (rd_sel_0 != PC_ADDR) && (pend[rd_sel_0] > CNT_W'(wb_hit_0));
    rd_busy_1 = (rd_sel_1 != PC_ADDR) && (pend[rd_sel_1] > CNT_W'(wb_hit_1));
  end

  // Debug view of the whole file with the live PC in its alias slot
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    if (r == PC_REG) begin : g_pc
      assign regs_flat[r*WIDTH +: WIDTH] = pc_in;
    end else begin : g_mem
      assign regs_flat[r*WIDTH +: WIDTH] = mem[r];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed table-driven bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   rd_sel_0, rd_sel_1;
  logic [31:0]  rd_data_0, rd_data_1;
  logic         rd_busy_0, rd_busy_1;
  logic [31:0]  pc_in;
  logic         issue_valid;
  logic [3:0]   issue_dst;
  logic         issue_stall;
  logic         wb_valid;
  logic [3:0]   wb_dst;
  logic [31:0]  wb_data;
  logic         sb_error;
  logic [511:0] regs_flat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rd_sel_0    (rd_sel_0),
    .rd_sel_1    (rd_sel_1),
    .rd_data_0   (rd_data_0),
    .rd_data_1   (rd_data_1),
    .rd_busy_0   (rd_busy_0),
    .rd_busy_1   (rd_busy_1),
    .pc_in       (pc_in),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_stall (issue_stall),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .sb_error    (sb_error),
    .regs_flat   (regs_flat)
  );

  typedef struct {
    logic [3:0]  s0, s1;
    logic        iv;
    logic [3:0]  id;
    logic        wv;
    logic [3:0]  wd;
    logic [31:0] wdat;
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_b1, e_st, e_err;
    logic [31:0] e_f0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [3:0] s0, input logic [3:0] s1,
    input logic iv, input logic [3:0] id,
    input logic wv, input logic [3:0] wd, input logic [31:0] wdat,
    input logic [31:0] e_d0, input logic [31:0] e_d1,
    input logic e_b0, input logic e_b1, input logic e_st, input logic e_err,
    input logic [31:0] e_f0);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.iv = iv; v.id = id;
    v.wv = wv; v.wd = wd; v.wdat = wdat;
    v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_b0 = e_b0; v.e_b1 = e_b1;
    v.e_st = e_st; v.e_err = e_err; v.e_f0 = e_f0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int r);
    return regs_flat[r*32 +: 32];
  endfunction

  task automatic drive(input logic rst, input logic [3:0] s0, input logic [3:0] s1,
                       input logic iv, input logic [3:0] id,
                       input logic wv, input logic [3:0] wd, input logic [31:0] wdat);
    @(negedge clk);
    reset = rst; rd_sel_0 = s0; rd_sel_1 = s1;
    issue_valid = iv; issue_dst = id;
    wb_valid = wv; wb_dst = wd; wb_data = wdat;
    #1;
  endtask

  task automatic idle(input logic [3:0] s0, input logic [3:0] s1);
    drive(1'b0, s0, s1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    pc_in = 32'h100;
    drive(1'b1, 4'd0, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    drive(1'b1, 4'd0, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);

    //            s0 s1 iv id wv wd wdat           e_d0           e_d1          b0 b1 st er e_f0
    vecs.push_back(mk(0, 15, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(14,15, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(3, 3,  1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(3, 3,  0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(3, 3,  0, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(3, 15, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h100,      0, 0, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(5, 3,  1, 5, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(5, 3,  1, 5, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(5, 3,  1, 5, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(5, 3,  1, 5, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(5, 3,  1, 5, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(5, 5,  1, 5, 1, 5, 32'h11,       32'h11,       32'h11,       1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(5, 15, 1, 5, 0, 0, 32'h0,        32'h11,       32'h100,      1, 0, 1, 0, 32'h11));
    vecs.push_back(mk(5, 15, 0, 0, 1, 5, 32'h21,       32'h21,       32'h100,      1, 0, 0, 0, 32'h11));
    vecs.push_back(mk(5, 15, 0, 0, 1, 5, 32'h22,       32'h22,       32'h100,      1, 0, 0, 0, 32'h21));
    vecs.push_back(mk(5, 15, 0, 0, 1, 5, 32'h23,       32'h23,       32'h100,      0, 0, 0, 0, 32'h22));
    vecs.push_back(mk(5, 15, 0, 0, 0, 0, 32'h0,        32'h23,       32'h100,      0, 0, 0, 0, 32'h23));
    vecs.push_back(mk(3, 15, 0, 0, 1, 7, 32'hCAFE0007, 32'hDEADBEEF, 32'h100,      0, 0, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(7, 15, 0, 0, 0, 0, 32'h0,        32'hCAFE0007, 32'h100,      0, 0, 0, 1, 32'hCAFE0007));

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].s0, vecs[i].s1, vecs[i].iv, vecs[i].id,
            vecs[i].wv, vecs[i].wd, vecs[i].wdat);
      chk($sformatf("v%0d rd_data_0", i), rd_data_0, vecs[i].e_d0);
      chk($sformatf("v%0d rd_data_1", i), rd_data_1, vecs[i].e_d1);
      chk($sformatf("v%0d rd_busy_0", i), {31'h0, rd_busy_0}, {31'h0, vecs[i].e_b0});
      chk($sformatf("v%0d rd_busy_1", i), {31'h0, rd_busy_1}, {31'h0, vecs[i].e_b1});
      chk($sformatf("v%0d issue_stall", i), {31'h0, issue_stall}, {31'h0, vecs[i].e_st});
      chk($sformatf("v%0d sb_error", i), {31'h0, sb_error}, {31'h0, vecs[i].e_err});
      chk($sformatf("v%0d regs_flat", i), slot(int'(vecs[i].s0)), vecs[i].e_f0);
    end

    // Sticky error persists across idle cycles
    for (int k = 0; k < 10; k++) begin
      idle(4'd7, 4'd15);
      chk($sformatf("sticky%0d sb_error", k), {31'h0, sb_error}, 32'h1);
    end

    // Write-back to the PC alias is discarded; issues to it never stall
    drive(1'b0, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 4'd15, 32'h55);
    chk("pcwb rd_data_0", rd_data_0, 32'h100);
    chk("pcwb slot15", slot(15), 32'h100);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'd15, 4'd0, 1'b1, 4'd15, 1'b0, 4'd0, 32'h0);
      chk($sformatf("pcissue%0d stall", k), {31'h0, issue_stall}, 32'h0);
      chk($sformatf("pcissue%0d busy", k), {31'h0, rd_busy_0}, 32'h0);
    end
    pc_in = 32'h200;
    idle(4'd15, 4'd15);
    chk("pcnext rd_data_0", rd_data_0, 32'h200);
    chk("pcnext slot15", slot(15), 32'h200);

    // Mid-operation reset drops outstanding counts and storage
    drive(1'b0, 4'd2, 4'd15, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 4'd2, 4'd15, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0);
    idle(4'd2, 4'd15);
    chk("pre-reset busy2", {31'h0, rd_busy_0}, 32'h1);
    drive(1'b1, 4'd2, 4'd15, 1'b1, 4'd2, 1'b1, 4'd9, 32'h99);
    idle(4'd2, 4'd9);
    chk("post-reset busy2", {31'h0, rd_busy_0}, 32'h0);
    chk("post-reset rd9", rd_data_1, 32'h0);
    chk("post-reset slot3", slot(3), 32'h0);
    chk("post-reset slot5", slot(5), 32'h0);
    chk("post-reset sb_error", {31'h0, sb_error}, 32'h0);
    drive(1'b0, 4'd2, 4'd15, 1'b0, 4'd0, 1'b1, 4'd2, 32'h77);
    chk("late wb bypass", rd_data_0, 32'h77);
    idle(4'd2, 4'd15);
    chk("late wb stored", rd_data_0, 32'h77);
    chk("late wb busy", {31'h0, rd_busy_0}, 32'h0);
    chk("late wb sb_error", {31'h0, sb_error}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with an integrated per-register write scoreboard and write-back bypass, replacing the fixed 16×32 falling-edge file in the pipelined core. Storage is written on the rising edge. A same-cycle write-back value is forwarded to the read ports. A saturating pending-write counter per register tells decode whether a source operand is still in flight. The block sits between decode (reads, issue) and write-back; hazard/stall logic consumes its busy flags.

## Interface
Parameters:
- WIDTH, 32, data width
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- PC_REG, 15, index of the program-counter alias; never stored
- MAX_INFLIGHT, 3, max outstanding writes per register; CNT_W = $clog2(MAX_INFLIGHT+1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- rd_sel_0, rd_sel_1  in  ADDR_W  read addresses
- rd_data_0, rd_data_1  out  WIDTH  read data, combinational
- rd_busy_0, rd_busy_1  out  1  source has an outstanding write not satisfied this cycle
- pc_in  in  WIDTH  value returned for reads of PC_REG
- issue_valid  in  1  an instruction that will write issue_dst is issuing
- issue_dst  in  ADDR_W  destination of the issuing instruction
- issue_stall  out  1  issue refused; counter for issue_dst is saturated
- wb_valid  in  1  write-back strobe
- wb_dst  in  ADDR_W  write-back destination
- wb_data  in  WIDTH  write-back value
- sb_error  out  1  sticky: write-back arrived with no pending write
- regs_flat  out  NUM_REGS*WIDTH  debug view; slot r at bits [r*WIDTH +: WIDTH]; slot PC_REG = pc_in

## Operation
- Reset: all stored registers 0, all counters 0, sb_error 0. Outputs follow combinationally: rd_data = 0 (or pc_in for PC_REG), busy 0, issue_stall 0.
- Read: rd_sel == PC_REG → pc_in. Else, wb_valid && wb_dst == rd_sel → wb_data (bypass). Else the stored value.
- Write: on clk when wb_valid && wb_dst != PC_REG, mem[wb_dst] ← wb_data. Writes to PC_REG are discarded; branch logic owns the PC.
- Counter pend[r] for r != PC_REG:
  - inc = issue_valid && issue_dst == r && !issue_stall
  - dec = wb_valid && wb_dst == r
  - inc && !dec: +1. dec && !inc: −1. Both or neither: hold.
- Underflow: dec with pend == 0 holds the counter at 0, still writes the data, and sets sb_error. sb_error clears only on reset.
- issue_stall = issue_valid && issue_dst != PC_REG && pend[issue_dst] == MAX_INFLIGHT && !(wb_valid && wb_dst == issue_dst). A stalled issue changes no state.
- Issue to PC_REG is never stalled and never counted.
- rd_busy_k = rd_sel_k != PC_REG && (pend[rd_sel_k] − (dec hit ? 1 : 0)) != 0. A final write-back being bypassed this cycle therefore clears busy.
- Reset has priority over all same-cycle issue and write-back.

## Timing
- Read path, bypass, busy and issue_stall are combinational: 0-cycle latency.
- Write-back is visible on the read port in the same cycle through the bypass, and from storage from the next cycle.
- A counter update is visible in busy and issue_stall the cycle after the edge.
- Reset asserted mid-operation clears every outstanding count on that edge; in-flight write-backs that arrive afterwards set sb_error. That is the required, documented behaviour.

## Structure
- Package regfile_pkg holds the ADDR_W/WIDTH defaults, the PC_REG constant and a cnt_width(max) function.
- Sub-module pending_counter: one CNT_W saturating up/down counter with an underflow pulse. It is instantiated NUM_REGS−1 times in a generate loop; the storage array and read muxes stay in the top.

## Test plan
- Reset, then read regs 0 and 14 with pc_in = 0x100 and rd_sel_1 = 15 → rd_data = 0, 0, 0x100; all busy 0; sb_error 0.
- Issue dst 3, next cycle read 3 → busy 1. Write-back 3 = 0xDEADBEEF, read 3 the same cycle → data 0xDEADBEEF, busy 0. Next cycle: storage holds 0xDEADBEEF, pend 0.
- Issue dst 5 three times (MAX_INFLIGHT = 3), then a fourth → issue_stall 1, pend stays 3. Repeat with a simultaneous wb to 5 → no stall, pend stays 3.
- Write-back to reg 7 with pend 0 → mem[7] updated, pend 0, sb_error 1 and still 1 ten cycles later.
- Write-back to 15 = 0x55 → rd_data for 15 stays pc_in; regs_flat slot 15 = pc_in; no counter change.
- Two issues to reg 2, then assert reset → pend 0, mem 0; a following wb to 2 sets sb_error.
